alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_8bit.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op encodings, sequencer states, datapath width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int WIDTH = 8;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_INC   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU; carry is only meaningful for ADD (carry out) and SUB (borrow).
// Latency: zero cycles, purely combinational.
// Backpressure: none, no handshake.
module alu_8bit
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] wide;

    // Op decode; INC wraps silently with carry held at 0.
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (sel)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOT:   result = ~a;
            OP_INC:   result = a + WIDTH'(1);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for alu_8bit: accepts a command, repeats it in_rep+1 times feeding the result back as A.
// Latency: accept on edge 0, out_valid rises after edge in_rep+1.
// Backpressure: one command in flight; in_ready low until the result is taken with out_ready in DONE.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int REP_W = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    input  logic [REP_W-1:0] in_rep,
    input  logic             in_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_carry_any,
    output logic             out_zero,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic [REP_W-1:0] iter_q, iter_d;
    logic             last_carry_q, last_carry_d;
    logic             carry_any_q, carry_any_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    alu_8bit u_alu (
        .a      (a_q),
        .b      (b_q),
        .sel    (sel_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Next-state and datapath: latch on accept, iterate in EXEC, hold everything in DONE.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        iter_d       = iter_q;
        last_carry_d = last_carry_q;
        carry_any_d  = carry_any_q;
        result_d     = result_q;
        zero_d       = zero_q;
        acc_d        = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d         = in_use_acc ? acc_q : in_a;
                    b_d         = in_b;
                    sel_d       = in_sel;
                    iter_d      = in_rep;
                    carry_any_d = 1'b0;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                a_d          = alu_result;
                last_carry_d = alu_carry;
                carry_any_d  = carry_any_q | alu_carry;
                if (iter_q == '0) begin
                    result_d = alu_result;
                    zero_d   = (alu_result == '0);
                    acc_d    = alu_result;
                    state_d  = ST_DONE;
                end else begin
                    iter_d = iter_q - REP_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any in-flight command and clears the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            iter_q       <= '0;
            last_carry_q <= 1'b0;
            carry_any_q  <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            iter_q       <= iter_d;
            last_carry_q <= last_carry_d;
            carry_any_q  <= carry_any_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            acc_q        <= acc_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign out_result    = result_q;
    assign out_carry     = last_carry_q;
    assign out_carry_any = carry_any_q;
    assign out_zero      = zero_q;
    assign acc           = acc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed test-plan scenarios plus randomized commands vs a reference model.
// Latency: checks result arrival after in_rep+1 edges.
// Backpressure: exercises stalled out_ready and ignored in_valid while DONE.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_sel = '0;
    logic [2:0] in_rep = '0;
    logic       in_use_acc = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_carry_any;
    logic       out_zero;
    logic [7:0] acc;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state and expectations for the most recent command.
    logic [7:0] acc_m = '0;
    logic [7:0] exp_res;
    logic       exp_c;
    logic       exp_ca;

    alu_op_sequencer #(.REP_W(3), .WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_sel        (in_sel),
        .in_rep        (in_rep),
        .in_use_acc    (in_use_acc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_carry     (out_carry),
        .out_carry_any (out_carry_any),
        .out_zero      (out_zero),
        .acc           (acc),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Behavioural model: apply the op rep+1 times using plain integer arithmetic.
    task automatic model_cmd(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] rep, input logic use_acc);
        int x, y, r, c, ca;
        x  = use_acc ? int'(acc_m) : int'(a);
        y  = int'(b);
        c  = 0;
        ca = 0;
        for (int i = 0; i <= int'(rep); i++) begin
            c = 0;
            case (sel)
                3'd0: begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
                3'd1: begin r = (x + 256 - y) % 256; c = (x < y) ? 1 : 0; end
                3'd2: r = x & y;
                3'd3: r = x | y;
                3'd4: r = x ^ y;
                3'd5: r = 255 - x;
                3'd6: r = (x + 1) % 256;
                default: r = 0;
            endcase
            if (c != 0) ca = 1;
            x = r;
        end
        exp_res = 8'(x);
        exp_c   = (c != 0);
        exp_ca  = (ca != 0);
        acc_m   = 8'(x);
    endtask

    // Drive one command and wait (bounded) for out_valid; returns edges after the accept edge.
    task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] rep, input logic use_acc, output int lat);
        model_cmd(sel, a, b, rep, use_acc);
        @(negedge clk);
        in_valid = 1'b1; in_sel = sel; in_a = a; in_b = b; in_rep = rep; in_use_acc = use_acc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy got %b/%b want 0/0", out_valid, busy); end
        checks++; if ({out_result, out_carry, out_carry_any, out_zero, acc} !== 19'd0) begin
            errors++; $display("FAIL reset_outputs got res=%h c=%b ca=%b z=%b acc=%h want all 0", out_result, out_carry, out_carry_any, out_zero, acc); end
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = '0;
    endtask

    task automatic test_add_carry();
        int lat;
        issue(3'd0, 8'hF0, 8'h20, 3'd0, 1'b0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++; if ({out_result, out_carry, out_carry_any, out_zero} !== {8'h10, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_result got %h c=%b ca=%b z=%b want 10 c=1 ca=1 z=0", out_result, out_carry, out_carry_any, out_zero); end
        checks++; if (acc !== 8'h10) begin errors++; $display("FAIL add_acc got %h want 10", acc); end
        consume();
    endtask

    task automatic test_sub_borrow();
        int lat;
        issue(3'd1, 8'h05, 8'h06, 3'd0, 1'b0, lat);
        checks++; if ({out_result, out_carry, out_zero} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sub_result got %h c=%b z=%b want ff c=1 z=0", out_result, out_carry, out_zero); end
        consume();
    endtask

    task automatic test_inc_repeat();
        int lat;
        issue(3'd6, 8'hFE, 8'h00, 3'd3, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL inc_latency got %0d want 4", lat); end
        checks++; if ({out_result, out_carry, out_carry_any, out_zero} !== {8'h02, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL inc_result got %h c=%b ca=%b z=%b want 02 c=0 ca=0 z=0", out_result, out_carry, out_carry_any, out_zero); end
        consume();
    endtask

    task automatic test_add_repeat_acc();
        int lat;
        issue(3'd0, 8'h80, 8'h80, 3'd2, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL addrep_latency got %0d want 3", lat); end
        checks++; if ({out_result, out_carry, out_carry_any, out_zero} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL addrep_result got %h c=%b ca=%b z=%b want 00 c=1 ca=1 z=1", out_result, out_carry, out_carry_any, out_zero); end
        consume();
        issue(3'd4, 8'h55, 8'h3C, 3'd0, 1'b1, lat);
        checks++; if ({out_result, out_carry, out_zero, acc} !== {8'h3C, 1'b0, 1'b0, 8'h3C}) begin
            errors++; $display("FAIL xor_acc got %h c=%b z=%b acc=%h want 3c c=0 z=0 acc=3c", out_result, out_carry, out_zero, acc); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [11:0] snap;
        issue(3'd3, 8'h0F, 8'hF0, 3'd1, 1'b0, lat);
        snap = {out_result, out_carry, out_carry_any, out_zero, out_valid};
        checks++; if (snap !== {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL bp_first got %h want %h", snap, {8'hFF, 4'b0001}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_sel = 3'd0; in_a = 8'($urandom); in_b = 8'($urandom); in_use_acc = 1'b0;
            @(posedge clk);
            #1;
            checks++; if ({out_result, out_carry, out_carry_any, out_zero, out_valid} !== snap || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cycle %0d got %h rdy=%b want %h rdy=0", i,
                    {out_result, out_carry, out_carry_any, out_zero, out_valid}, in_ready, snap); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b vld=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
        in_valid = 1'b0;
        checks++; if (acc !== 8'hFF) begin errors++; $display("FAIL bp_acc got %h want ff", acc); end
    endtask

    task automatic test_reset_mid_exec();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_sel = 3'd0; in_a = 8'h01; in_b = 8'h01; in_rep = 3'd7; in_use_acc = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || acc !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid got vld=%b acc=%h busy=%b rdy=%b want 0/00/0/1", out_valid, acc, busy, in_ready); end
        acc_m = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        issue(3'd0, 8'h01, 8'h01, 3'd0, 1'b0, lat);
        checks++; if (out_result !== 8'h02 || lat !== 1) begin
            errors++; $display("FAIL rst_after got %h lat=%0d want 02 lat=1", out_result, lat); end
        consume();
    endtask

    task automatic test_random();
        int lat;
        logic [2:0] sel, rep;
        logic [7:0] a, b;
        logic ua;
        for (int n = 0; n < 40; n++) begin
            sel = 3'($urandom); rep = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            ua  = 1'($urandom_range(0, 1));
            issue(sel, a, b, rep, ua, lat);
            checks++; if (lat !== int'(rep) + 1) begin errors++; $display("FAIL rnd_latency n=%0d got %0d want %0d", n, lat, int'(rep) + 1); end
            checks++; if ({out_result, out_carry, out_carry_any, out_zero, acc} !== {exp_res, exp_c, exp_ca, (exp_res == 8'h00), acc_m}) begin
                errors++; $display("FAIL rnd_result n=%0d sel=%0d got %h c=%b ca=%b z=%b acc=%h want %h c=%b ca=%b z=%b acc=%h",
                    n, sel, out_result, out_carry, out_carry_any, out_zero, acc, exp_res, exp_c, exp_ca, (exp_res == 8'h00), acc_m); end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_inc_repeat();
        test_add_repeat_acc();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
